dvsd_pd: RTL and testbench
==========================

# dvsd_pd

Sequential 3-to-8 priority decoder: the receive end of the `dvsd_pe` encoder interface. Accepts an encoded request (`code`, `gs`) under a valid/ready handshake and drives a registered one-hot grant on the matching line. The grant is held until that line acknowledges or a programmable timeout expires. It sits downstream of `dvsd_pe` and turns its 3-bit priority code back into a per-requester grant.

## Interface
- `HOLD_MAX`, default 15: maximum grant hold, in cycles minus one; width 4 bits; legal range 0..15.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable, same sense as the encoder's `en`.
- `in_valid`  in  1  `code`/`gs` are valid this cycle.
- `in_ready`  out  1  decoder can accept a transfer.
- `code`  in  3  encoded index of the highest-priority requester.
- `gs`  in  1  group select: 1 means a request is present.
- `ack`  in  8  per-line release; only the bit of the granted line is honoured.
- `grant`  out  8  registered one-hot grant; `grant[code]`.
- `grant_valid`  out  1  high while `grant` is non-zero.
- `eno`  out  1  one-cycle pulse when an enabled transfer carried `gs=0` (no requester).
- `timeout`  out  1  one-cycle pulse when a grant is released by expiry.

## Operation
- States: IDLE, GRANT, RELEASE.
- Transfer: occurs on a rising edge with `in_valid & in_ready`.
- `in_ready`: equals `en` in IDLE and is 0 otherwise.
- IDLE, transfer with `gs=1`:
  - `grant <= 1<<code`, `grant_valid <= 1`.
  - Latch `code` into `cur`; load `cnt <= HOLD_MAX`; go to GRANT.
- IDLE, transfer with `gs=0`: `eno <= 1` for one cycle; stay in IDLE; `grant` stays 0.
- IDLE, `en=0`: no transfer; `in_valid` is ignored.
- GRANT: checks in priority order, evaluated each edge:
  1. `en=0`: clear `grant`/`grant_valid`, go to IDLE. No `timeout` pulse.
  2. `ack[cur]=1`: clear grant, go to RELEASE.
  3. `cnt==0`: clear grant, `timeout <= 1`, go to RELEASE.
  4. Otherwise: `cnt <= cnt-1`.
- Ack and expiry in the same cycle: ack wins and `timeout` stays 0.
- `ack` bits other than `ack[cur]` are ignored in every state.
- RELEASE: lasts one cycle with `grant=0` and `in_ready=0`, then goes to IDLE. This guarantees a one-cycle gap between consecutive grants.
- `code` is always 0..7, so every value decodes; no illegal input exists.
- Counter: 4-bit, no wrap. It stops at 0 because the state exits there.
- Reset values, all forced immediately on `rst_n` low, including mid-grant:
  - `grant=0`, `grant_valid=0`, `eno=0`, `timeout=0`, `in_ready=0`.
  - State = IDLE, `cnt=0`, `cur=0`.
- `in_ready` goes high on the first edge after reset release if `en=1`.

## Timing
- Accept-to-grant latency: 1 cycle. `grant` is visible in the cycle after the accepting edge.
- Grant with no ack: `grant_valid` is high for exactly `HOLD_MAX+1` cycles. `timeout` pulses in the following cycle, which is the RELEASE cycle.
- Grant with ack: if `ack[cur]` is sampled high at edge k, `grant` is 0 after edge k.
- Minimum spacing between grants: 3 cycles (GRANT → RELEASE → IDLE accept → GRANT).
- `eno` and `timeout` are registered single-cycle pulses and never assert together.
- No combinational path from inputs to outputs except `en` → `in_ready`.

## Structure
- Package `dvsd_pd_pkg`:
  - State enum {IDLE, GRANT, RELEASE}.
  - `NLINES=8`, `CODE_W=3`, `CNT_W=4`.
- Sub-module `dvsd_dec3to8`: purely combinational decoder, `code[2:0]` → `onehot[7:0]`. It is instantiated once, and its output is registered in `dvsd_pd`.

## Test plan
- Reset mid-grant:
  - Stimulus: with `grant=8'h10`, drive `rst_n` low between edges.
  - Required: `grant=0` and `grant_valid=0` immediately; after release with `en=1`, `in_ready=1` one edge later.
- Sweep:
  - Stimulus: `en=1`, `gs=1`, `code`=0..7, each transfer acked 2 cycles after its grant appears.
  - Required: `grant` = 01, 02, 04 … 80 in order; `timeout` never asserts; 3-cycle minimum spacing holds.
- Timeout, with `HOLD_MAX=3`:
  - Stimulus: `code=5`, no ack.
  - Required: `grant=8'h20` for 4 cycles, then `timeout=1` for 1 cycle with `grant=0`, then `in_ready=1`.
- Ack/expiry collision:
  - Stimulus: `ack[cur]` arrives exactly in the `cnt==0` cycle.
  - Required: released with `timeout=0`.
  - Also: `ack=8'h01` while `grant=8'h80` → ignored, grant held.
- `gs=0` and `en` abort:
  - Stimulus: `gs=0` transfer.
  - Required: `eno` pulses once and `grant` stays 0.
  - Stimulus: drop `en` during GRANT.
  - Required: grant cleared next edge, no `timeout`, `in_ready=0` while `en=0`.
- Round trip with `dvsd_pe`:
  - Stimulus: encoder `in=8'b0100_1000`, `en=1`.
  - Required: decoder `grant=8'h40` (highest-priority bit).

Source files
------------

// File: rtl/dvsd_pd_pkg.sv
// dvsd_pd_pkg: shared types and sizes for the dvsd_pd priority decoder.
//   state_t : decoder FSM states (IDLE, GRANT, RELEASE)
//   NLINES  : number of grant lines
//   CODE_W  : width of the encoded request index
//   CNT_W   : width of the grant-hold counter
package dvsd_pd_pkg;

    localparam int unsigned NLINES = 8;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

endpackage

// File: rtl/dvsd_dec3to8.sv
// dvsd_dec3to8: purely combinational 3-to-8 one-hot decoder.
//   code   in  [CODE_W-1:0]  index to decode (every value is legal)
//   onehot out [NLINES-1:0]  one-hot vector with bit 'code' set
module dvsd_dec3to8
    import dvsd_pd_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [NLINES-1:0] onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/dvsd_pd.sv
// dvsd_pd: sequential 3-to-8 priority decoder, receive end of dvsd_pe.
// Accepts (code, gs) under valid/ready and holds a registered one-hot grant
// until the granted line acks, the hold timer expires, or en drops.
//   HOLD_MAX     param  grant hold length minus one (0..15)
//   clk          in     rising-edge clock
//   rst_n        in     asynchronous active-low reset
//   en           in     block enable
//   in_valid     in     code/gs valid
//   in_ready     out    transfer can be accepted (IDLE and en)
//   code         in     [2:0] encoded requester index
//   gs           in     1 = a request is present
//   ack          in     [7:0] per-line release, only ack[cur] honoured
//   grant        out    [7:0] registered one-hot grant
//   grant_valid  out    grant is non-zero
//   eno          out    one-cycle pulse for an enabled transfer with gs=0
//   timeout      out    one-cycle pulse when a grant expires
module dvsd_pd
    import dvsd_pd_pkg::*;
#(
    parameter logic [CNT_W-1:0] HOLD_MAX = 4'd15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code,
    input  logic              gs,
    input  logic [NLINES-1:0] ack,
    output logic [NLINES-1:0] grant,
    output logic              grant_valid,
    output logic              eno,
    output logic              timeout
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CODE_W-1:0]  cur;
    logic [NLINES-1:0]  dec_onehot;
    logic               armed;
    logic               xfer;

    dvsd_dec3to8 u_dec (
        .code   (code),
        .onehot (dec_onehot)
    );

    // armed keeps in_ready low during reset and until the first edge after
    // release, even though IDLE is the reset state.
    always_comb begin
        in_ready = en & armed & (state == IDLE);
        xfer     = in_valid & in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cur         <= '0;
            armed       <= 1'b0;
            grant       <= '0;
            grant_valid <= 1'b0;
            eno         <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            armed   <= 1'b1;
            eno     <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (gs) begin
                            grant       <= dec_onehot;
                            grant_valid <= 1'b1;
                            cur         <= code;
                            cnt         <= HOLD_MAX;
                            state       <= GRANT;
                        end else begin
                            eno <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    // Priority: enable abort, then ack, then expiry.
                    if (!en) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else if (ack[cur]) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= RELEASE;
                    end else if (cnt == '0) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        timeout     <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvsd_pd.sv
// tb_dvsd_pd: scoreboard bench for dvsd_pd. Stimulus pushes transaction-level
// expectations (grant value, hold length, release by timeout or not, eno);
// a monitor reconstructs transactions from the DUT outputs and compares.
module tb_dvsd_pd;
    localparam int H = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] code;
    logic       gs;
    logic [7:0] ack;
    logic [7:0] grant;
    logic       grant_valid;
    logic       eno;
    logic       timeout;

    dvsd_pd #(.HOLD_MAX(4'(H))) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .code        (code),
        .gs          (gs),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .eno         (eno),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 = grant, 1 = eno
        logic [7:0] gval;
        int         hold;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Behavioural dvsd_pe: index of highest set bit, gs = any bit set.
    function automatic logic [3:0] pe_model(input logic [7:0] req);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 8; i++)
            if (req[i]) r = {1'b1, 3'(i)};
        return r;
    endfunction

    // ---------------- monitor ----------------
    bit         in_grant = 0;
    logic [7:0] cur_g;
    int         hold_cnt;
    int         cyc = 0;
    int         last_start = -100;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_grant = 0;
        end else begin
            if (grant_valid) begin
                if (!in_grant) begin
                    chk("grant_spacing", (cyc - last_start) >= 3, 1);
                    chk("grant_nonzero", grant != 8'h00, 1);
                    in_grant   = 1;
                    cur_g      = grant;
                    hold_cnt   = 1;
                    last_start = cyc;
                end else begin
                    hold_cnt++;
                    if (grant != cur_g) chk("grant_stable", grant, cur_g);
                end
                if (in_ready) chk("ready_during_grant", in_ready, 0);
                if (timeout) chk("timeout_during_grant", timeout, 0);
            end else begin
                if (grant != 8'h00) chk("grant_without_valid", grant, 0);
                if (in_grant) begin
                    in_grant = 0;
                    chk("grant_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("event_kind_grant", 0, e.kind);
                        chk("grant_value", cur_g, e.gval);
                        chk("grant_hold", hold_cnt, e.hold);
                        chk("release_timeout", timeout, e.tmo);
                    end
                end else if (timeout) begin
                    chk("stray_timeout", timeout, 0);
                end
            end
            if (eno) begin
                chk("eno_timeout_excl", timeout, 0);
                chk("eno_grant_zero", grant, 0);
                chk("eno_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("event_kind_eno", 1, e.kind);
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(output bit got);
        got = 0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (in_ready) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("ready_wait", got, 1);
    endtask

    // ack_k: edge (after accept) at which ack[c] is sampled, 0 = none.
    // drop_k: edge at which en is sampled low, 0 = none.
    // noise: 0 none, 1 random non-granted ack bits, 2 constant 8'h01.
    task automatic do_grant(input logic [2:0] c, input int ack_k, input int drop_k, input int noise);
        bit   got;
        exp_t e;
        int   fin;
        bit   by_ack;
        bit   by_drop;
        logic [7:0] mine;
        mine     = 8'h01 << c;
        en       = 1'b1;
        gs       = 1'b1;
        code     = c;
        in_valid = 1'b1;
        wait_ready(got);
        if (!got) begin
            in_valid = 1'b0;
            return;
        end
        by_ack  = (ack_k  >= 1 && ack_k  <= H + 1);
        by_drop = (drop_k >= 1 && drop_k <= H + 1);
        fin = H + 1;
        if (by_ack && ack_k < fin) fin = ack_k;
        if (by_drop && drop_k < fin) fin = drop_k;
        e.kind = 0;
        e.gval = mine;
        e.hold = fin;
        e.tmo  = !by_ack && !by_drop;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= H + 1; k++) begin
            case (noise)
                1:       ack = 8'($urandom) & ~mine;
                2:       ack = 8'h01 & ~mine;
                default: ack = 8'h00;
            endcase
            if (k == ack_k) ack = ack | mine;
            if (k == drop_k) en = 1'b0;
            @(posedge clk);
            #1;
            if (k == ack_k || k == drop_k) break;
        end
        ack = 8'h00;
        if (!en) begin
            #1;
            chk("ready_en_low", in_ready, 0);
            en = 1'b1;
        end
    endtask

    task automatic do_empty(input logic [2:0] c);
        bit   got;
        exp_t e;
        en       = 1'b1;
        gs       = 1'b0;
        code     = c;
        in_valid = 1'b1;
        wait_ready(got);
        if (!got) begin
            in_valid = 1'b0;
            return;
        end
        e.kind = 1;
        e.gval = 8'h00;
        e.hold = 0;
        e.tmo  = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] pe;
        bit         got;
        rst_n    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        code     = 3'd0;
        gs       = 1'b0;
        ack      = 8'h00;
        #2;
        chk("reset_grant", grant, 0);
        chk("reset_grant_valid", grant_valid, 0);
        chk("reset_ready", in_ready, 0);
        chk("reset_eno", eno, 0);
        chk("reset_timeout", timeout, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_first_edge", in_ready, 1);

        // Sweep, acked two cycles after the grant appears.
        for (int c = 0; c < 8; c++) do_grant(3'(c), 2, 0, 0);

        // Timeout with no ack, then RELEASE, then ready.
        do_grant(3'd5, 0, 0, 0);
        chk("ready_in_release", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_release", in_ready, 1);

        // Ack exactly in the expiry cycle; foreign ack on line 7.
        do_grant(3'd2, H + 1, 0, 0);
        do_grant(3'd7, 0, 0, 2);
        do_grant(3'd7, 3, 0, 2);

        // gs=0 transfer, en abort mid-grant, in_valid ignored while en=0.
        do_empty(3'd3);
        do_grant(3'd1, 0, 2, 0);
        en       = 1'b0;
        gs       = 1'b1;
        code     = 3'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ready_disabled", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        en       = 1'b1;

        // Round trip through a behavioural encoder.
        pe = pe_model(8'b0100_1000);
        if (pe[3]) do_grant(pe[2:0], 2, 0, 0);
        else do_empty(pe[2:0]);

        // Randomised mix.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) do_empty(3'($urandom));
            else do_grant(3'($urandom), int'($urandom_range(0, H + 2)),
                          (r == 1) ? int'($urandom_range(2, H + 1)) : 0,
                          int'($urandom_range(0, 1)));
        end

        // Reset in the middle of a grant on line 4.
        en       = 1'b1;
        gs       = 1'b1;
        code     = 3'd4;
        in_valid = 1'b1;
        wait_ready(got);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_reset_grant", grant, 8'h01 << 4);
        rst_n = 1'b0;
        #1;
        chk("midreset_grant", grant, 0);
        chk("midreset_grant_valid", grant_valid, 0);
        chk("midreset_ready", in_ready, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge_2", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge_2", in_ready, 1);

        for (int t = 0; t < 50; t++) begin
            if (exp_q.size() == 0 && !in_grant) break;
            @(posedge clk);
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
